// File: rtl/estagio_id_ex.sv
// estagio_id_ex: ID/EX pipeline register with operand bypass, immediate extension and ULA op decode (bypass enabled by ESTAGIO_ID_EX_FWD_EN)
module estagio_id_ex (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_reg_write,
    input  logic        reg_dst,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [4:0]  rs_idx,
    input  logic [4:0]  rt_idx,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        exmem_wr,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_val,
    input  logic        memwb_wr,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_val,
    output logic [31:0] ula_a,
    output logic [31:0] ula_b,
    output logic [3:0]  ula_op,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic [4:0]  out_dest,
    output logic [31:0] out_store,
    output logic        out_illegal
);
    logic [31:0] rs_sel, rt_sel, imm_ext;
    logic [3:0]  funct_op, imm_op, op_next;
    logic        illegal_next;

`ifdef ESTAGIO_ID_EX_FWD_EN
    // EX/MEM has the newer value, so it is checked first; register 0 is hardwired and never bypassed
    assign rs_sel = (rs_idx != 5'd0 && exmem_wr && exmem_rd == rs_idx) ? exmem_val :
                    (rs_idx != 5'd0 && memwb_wr && memwb_rd == rs_idx) ? memwb_val : rs_data;
    assign rt_sel = (rt_idx != 5'd0 && exmem_wr && exmem_rd == rt_idx) ? exmem_val :
                    (rt_idx != 5'd0 && memwb_wr && memwb_rd == rt_idx) ? memwb_val : rt_data;
`else
    logic unused_bypass;
    assign unused_bypass = ^{exmem_wr, exmem_rd, exmem_val, memwb_wr, memwb_rd, memwb_val};
    assign rs_sel = rs_data;
    assign rt_sel = rt_data;
`endif

    // logical immediates (andi/ori) zero-extend, everything else sign-extends
    assign imm_ext = (opcode == 6'b001100 || opcode == 6'b001101) ? {16'd0, imm} : {{16{imm[15]}}, imm};

    // decode the ULA operation from alu_op, funct (R-type) or opcode (immediate ops)
    always_comb begin
        funct_op = 4'b1111;
        imm_op   = 4'b0010;
        case (funct)
            6'b100000: funct_op = 4'b0010;
            6'b100010: funct_op = 4'b0110;
            6'b100100: funct_op = 4'b0000;
            6'b100101: funct_op = 4'b0001;
            6'b101010: funct_op = 4'b0111;
            6'b100111: funct_op = 4'b1100;
            default:   funct_op = 4'b1111;
        endcase
        case (opcode)
            6'b001100: imm_op = 4'b0000;
            6'b001101: imm_op = 4'b0001;
            6'b001010: imm_op = 4'b0111;
            default:   imm_op = 4'b0010;
        endcase
        op_next = alu_op == 2'b00 ? 4'b0010 :
                  alu_op == 2'b01 ? 4'b0110 :
                  alu_op == 2'b10 ? funct_op : imm_op;
        illegal_next = in_valid && alu_op == 2'b10 && funct_op == 4'b1111;
    end

    // reset and flush both clear the stage; stall holds; otherwise capture the decoded instruction
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ula_a         <= '0;
            ula_b         <= '0;
            ula_op        <= '0;
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_dest      <= '0;
            out_store     <= '0;
            out_illegal   <= 1'b0;
        end else if (!stall) begin
            ula_a         <= rs_sel;
            ula_b         <= alu_src ? imm_ext : rt_sel;
            ula_op        <= op_next;
            out_valid     <= in_valid;
            out_reg_write <= in_reg_write & in_valid;
            out_dest      <= reg_dst ? rd_idx : rt_idx;
            out_store     <= rt_sel;
            out_illegal   <= illegal_next;
        end
    end
endmodule

// File: tb/tb_estagio_id_ex.sv
// tb_estagio_id_ex: directed and randomized checks of estagio_id_ex against a behavioural model
module tb_estagio_id_ex;
    logic        clock = 1'b0;
    logic        reset, stall, flush, in_valid, in_reg_write, reg_dst, alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic [4:0]  rs_idx, rt_idx, rd_idx, exmem_rd, memwb_rd;
    logic [31:0] rs_data, rt_data, exmem_val, memwb_val;
    logic        exmem_wr, memwb_wr;
    logic [31:0] ula_a, ula_b, out_store;
    logic [3:0]  ula_op;
    logic        out_valid, out_reg_write, out_illegal;
    logic [4:0]  out_dest;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        valid;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] store;
        logic        illegal;
    } outs_t;

    outs_t exp_o, got, saved;
    int checks = 0;
    int errors = 0;

    assign got = {ula_a, ula_b, ula_op, out_valid, out_reg_write, out_dest, out_store, out_illegal};

    always #5 clock = ~clock;

    estagio_id_ex dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .alu_op(alu_op), .opcode(opcode), .funct(funct), .imm(imm),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .rs_data(rs_data), .rt_data(rt_data),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .out_valid(out_valid),
        .out_reg_write(out_reg_write), .out_dest(out_dest), .out_store(out_store),
        .out_illegal(out_illegal)
    );

    // value an instruction sees for register idx, given what older instructions are writing
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] file_val);
`ifdef ESTAGIO_ID_EX_FWD_EN
        if (idx == 0) return file_val;
        if (exmem_wr && exmem_rd == idx) return exmem_val;
        if (memwb_wr && memwb_rd == idx) return memwb_val;
`endif
        return file_val;
    endfunction

    function automatic outs_t model(input outs_t cur);
        outs_t n;
        int r_funct[6] = '{32, 34, 36, 37, 42, 39};
        int r_code[6]  = '{2, 6, 0, 1, 7, 12};
        int i_opc[4]   = '{8, 12, 13, 10};
        int i_code[4]  = '{2, 0, 1, 7};
        int ext;
        if (reset || flush) return '0;
        if (stall) return cur;
        ext = (opcode == 12 || opcode == 13) ? int'(imm) : int'($signed(imm));
        n.a       = operand(rs_idx, rs_data);
        n.store   = operand(rt_idx, rt_data);
        n.b       = alu_src ? ext : n.store;
        n.valid   = in_valid;
        n.rw      = in_valid && in_reg_write;
        n.dest    = reg_dst ? rd_idx : rt_idx;
        n.illegal = 1'b0;
        if (alu_op == 0) n.op = 2;
        else if (alu_op == 1) n.op = 6;
        else if (alu_op == 2) begin
            n.op = 15;
            foreach (r_funct[k]) if (funct == r_funct[k]) n.op = 4'(r_code[k]);
            n.illegal = (n.op == 15) && in_valid;
        end else begin
            n.op = 2;
            foreach (i_opc[k]) if (opcode == i_opc[k]) n.op = 4'(i_code[k]);
        end
        return n;
    endfunction

    task automatic randomize_inputs();
        int fl[8] = '{32, 34, 36, 37, 42, 39, 0, 5};
        int ol[6] = '{8, 12, 13, 10, 4, 35};
        in_valid     = 1'($urandom);
        in_reg_write = 1'($urandom);
        reg_dst      = 1'($urandom);
        alu_src      = 1'($urandom);
        alu_op       = 2'($urandom);
        funct        = 6'(fl[$urandom_range(0, 7)]);
        opcode       = 6'(ol[$urandom_range(0, 5)]);
        imm          = 16'($urandom);
        rs_idx       = 5'($urandom_range(0, 3));
        rt_idx       = 5'($urandom_range(0, 3));
        rd_idx       = 5'($urandom);
        rs_data      = $urandom;
        rt_data      = $urandom;
        exmem_wr     = 1'($urandom);
        exmem_rd     = 5'($urandom_range(0, 3));
        exmem_val    = $urandom;
        memwb_wr     = 1'($urandom);
        memwb_rd     = 5'($urandom_range(0, 3));
        memwb_val    = $urandom;
    endtask

    task automatic quiet();
        reset = 0; stall = 0; flush = 0;
        exmem_wr = 0; memwb_wr = 0;
    endtask

    // predict the next state, then advance one edge and settle
    task automatic step();
        exp_o = model(exp_o);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        randomize_inputs();
        reset = 1; stall = 1; flush = 0; in_valid = 1;
        step();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset: got %h required 0", got);
        end
        reset = 0;
    endtask

    task automatic test_rtype_sub();
        randomize_inputs(); quiet();
        in_valid = 1; alu_op = 2'b10; funct = 6'b100010; alu_src = 0;
        rs_data = 7; rt_data = 3; reg_dst = 1; rd_idx = 9;
        step();
        checks++;
        if ({ula_a, ula_b, ula_op, out_dest, out_valid} !== {32'd7, 32'd3, 4'b0110, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL rtype_sub: a=%0d b=%0d op=%b dest=%0d v=%b required 7 3 0110 9 1",
                     ula_a, ula_b, ula_op, out_dest, out_valid);
        end
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL rtype_sub_model: got %h required %h", got, exp_o);
        end
    endtask

    task automatic test_imm_ext();
        randomize_inputs(); quiet();
        imm = 16'hFFFF; alu_src = 1; alu_op = 2'b11; opcode = 6'b001100;
        step();
        checks++;
        if ({ula_b, ula_op} !== {32'h0000FFFF, 4'b0000}) begin
            errors++;
            $display("FAIL andi_ext: b=%h op=%b required 0000ffff 0000", ula_b, ula_op);
        end
        opcode = 6'b001000;
        step();
        checks++;
        if ({ula_b, ula_op} !== {32'hFFFFFFFF, 4'b0010}) begin
            errors++;
            $display("FAIL addi_ext: b=%h op=%b required ffffffff 0010", ula_b, ula_op);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        randomize_inputs(); quiet();
        rs_data = 32'h11; rs_idx = 5;
        exmem_wr = 1; exmem_rd = 5; exmem_val = 32'hAA;
        memwb_wr = 1; memwb_rd = 5; memwb_val = 32'hBB;
`ifdef ESTAGIO_ID_EX_FWD_EN
        want = 32'hAA;
`else
        want = 32'h11;
`endif
        step();
        checks++;
        if (ula_a !== want) begin
            errors++;
            $display("FAIL bypass_exmem: a=%h required %h", ula_a, want);
        end
        rs_idx = 0; exmem_rd = 0; memwb_rd = 0;
        step();
        checks++;
        if (ula_a !== 32'h11) begin
            errors++;
            $display("FAIL bypass_r0: a=%h required 00000011", ula_a);
        end
        rt_idx = 3; exmem_wr = 0; memwb_rd = 3; alu_src = 0;
`ifdef ESTAGIO_ID_EX_FWD_EN
        want = 32'hBB;
`else
        want = rt_data;
`endif
        step();
        checks++;
        if ({out_store, ula_b} !== {want, want}) begin
            errors++;
            $display("FAIL bypass_memwb_rt: store=%h b=%h required %h", out_store, ula_b, want);
        end
    endtask

    task automatic test_stall_flush();
        randomize_inputs(); quiet();
        in_valid = 1; in_reg_write = 1;
        step();
        saved = got;
        checks++;
        if (got !== exp_o || out_valid !== 1'b1 || out_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL stall_capture: got %h required %h", got, exp_o);
        end
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(); quiet();
            stall = 1;
            step();
            checks++;
            if (got !== saved) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h required %h", i, got, saved);
            end
        end
        stall = 1; flush = 1;
        step();
        checks++;
        if ({out_valid, out_reg_write, out_illegal} !== 3'b000 || got !== exp_o) begin
            errors++;
            $display("FAIL stall_flush: got %h required %h", got, exp_o);
        end
        quiet();
    endtask

    task automatic test_illegal();
        randomize_inputs(); quiet();
        alu_op = 2'b10; funct = 6'b000000; in_valid = 1;
        step();
        checks++;
        if ({ula_op, out_illegal} !== {4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL illegal_valid: op=%b ill=%b required 1111 1", ula_op, out_illegal);
        end
        in_valid = 0;
        step();
        checks++;
        if ({ula_op, out_illegal, out_valid} !== {4'b1111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL illegal_invalid: op=%b ill=%b v=%b required 1111 0 0", ula_op, out_illegal, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            randomize_inputs(); quiet();
            step();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL back_to_back%0d: got %h required %h", i, got, exp_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL random%0d: got %h required %h", i, got, exp_o);
            end
        end
        quiet();
    endtask

    task automatic test_reset_mid_stall();
        randomize_inputs(); quiet();
        in_valid = 1;
        step();
        stall = 1;
        step();
        reset = 1;
        step();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h required 0", got);
        end
        randomize_inputs(); quiet();
        step();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL post_reset_capture: got %h required %h", got, exp_o);
        end
    endtask

    initial begin
        exp_o = '0;
        quiet();
        @(negedge clock);
        test_reset();
        test_rtype_sub();
        test_imm_ext();
        test_bypass();
        test_stall_flush();
        test_illegal();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/estagio_id_ex.md
ESTAGIO_ID_EX -- requirements
Module: estagio_id_ex

Interface
REQ-001 The block SHALL have the port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the ports: stall  input  1  hold current contents; flush  input  1  load bubble.
REQ-004 The block SHALL have the ports: in_valid  input  1; in_reg_write  input  1; reg_dst  input  1; alu_src  input  1; alu_op  input  2.
REQ-005 The block SHALL have the ports: opcode  input  6; funct  input  6; imm  input  16; rs_idx, rt_idx, rd_idx  input  5 each.
REQ-006 The block SHALL have the ports: rs_data, rt_data  input  32  register-file read values.
REQ-007 The block SHALL have the bypass ports: exmem_wr  input  1; exmem_rd  input  5; exmem_val  input  32; memwb_wr  input  1; memwb_rd  input  5; memwb_val  input  32.
REQ-008 The block SHALL have the outputs: ula_a, ula_b  output  32  ULA operands; ula_op  output  4  ULA operation select.
REQ-009 The block SHALL have the outputs: out_valid  output  1; out_reg_write  output  1; out_dest  output  5; out_store  output  32  forwarded rt value; out_illegal  output  1.

Function
REQ-010 All outputs SHALL be registered; capture latency SHALL be one clock edge.
REQ-011 Per-edge update priority SHALL be: reset > flush > stall > capture.
REQ-012 flush=1 SHALL load a bubble: out_valid=0, out_reg_write=0, out_illegal=0; flush overrides a simultaneous stall.
REQ-013 stall=1 without flush SHALL hold every output unchanged, regardless of other inputs.
REQ-014 Capture SHALL register out_valid=in_valid and out_reg_write=in_reg_write&in_valid.
REQ-015 Operand selection for rs: exmem_val if exmem_wr and exmem_rd==rs_idx and rs_idx!=0; else memwb_val if memwb_wr and memwb_rd==rs_idx and rs_idx!=0; else rs_data.
REQ-016 Operand selection for rt SHALL use the same rule with rt_idx; EX/MEM SHALL win over MEM/WB when both match.
REQ-017 Register index 0 SHALL never be bypassed; its value SHALL come from rs_data/rt_data.
REQ-018 ula_a SHALL capture the selected rs value; out_store SHALL capture the selected rt value.
REQ-019 ula_b SHALL capture the extended immediate when alu_src=1, else the selected rt value.
REQ-020 Immediate extension: zero-extend for opcode 001100 (andi) and 001101 (ori); sign-extend for all other opcodes.
REQ-021 out_dest SHALL capture rd_idx when reg_dst=1, else rt_idx.
REQ-022 ula_op decode for alu_op=00 SHALL be 0010; for alu_op=01 it SHALL be 0110.
REQ-023 ula_op decode for alu_op=10 SHALL follow funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-024 An unlisted funct with alu_op=10 SHALL give ula_op=1111 and out_illegal=in_valid; otherwise out_illegal=0.
REQ-025 ula_op decode for alu_op=11 SHALL follow opcode: 001000->0010, 001100->0000, 001101->0001, 001010->0111; any other opcode SHALL give 0010.
REQ-026 Operand values and ula_op SHALL be captured even when in_valid=0; consumers SHALL qualify them with out_valid.

Reset
REQ-027 reset=1 at an edge SHALL clear every output to zero (ula_op=0000, out_valid=0), overriding flush, stall and capture, including mid-stall.
REQ-028 Outputs SHALL capture normally on the first edge after reset deasserts.

Configuration
REQ-029 With macro ESTAGIO_ID_EX_FWD_EN defined, the bypass of REQ-015..017 SHALL be compiled in.
REQ-030 Without ESTAGIO_ID_EX_FWD_EN, rs_data/rt_data SHALL be used directly; the bypass ports SHALL remain present but SHALL be ignored.

Verification
REQ-031 Reset: assert reset with stall=1 and in_valid=1 -> next edge all outputs 0, ula_op=0000.
REQ-032 R-type sub: alu_op=10, funct=100010, rs_data=7, rt_data=3, reg_dst=1, rd_idx=9 -> ula_a=7, ula_b=3, ula_op=0110, out_dest=9, out_valid=1.
REQ-033 andi/addi extension: imm=0xFFFF, alu_src=1; opcode 001100 -> ula_b=0x0000FFFF, ula_op=0000; opcode 001000 -> ula_b=0xFFFFFFFF, ula_op=0010.
REQ-034 Bypass (FWD_EN defined): rs_idx=5, exmem_wr=1, exmem_rd=5, exmem_val=0xAA, memwb_wr=1, memwb_rd=5, memwb_val=0xBB -> ula_a=0xAA. Same with rs_idx=0 -> ula_a=rs_data. Without FWD_EN -> ula_a=rs_data.
REQ-035 Stall/flush: capture a valid op, then apply stall=1 for 3 cycles with changed inputs -> outputs unchanged; then stall=1 with flush=1 -> out_valid=0, out_reg_write=0.
REQ-036 Illegal funct: alu_op=10, funct=000000, in_valid=1 -> ula_op=1111, out_illegal=1; same with in_valid=0 -> out_illegal=0.
